// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Host-side command engine for the UART top.  It drains bytes from the UART
//   RX FIFO and parses them into register commands:
//     write: OP_WR addr data -> one reg_we strobe, then ACK_BYTE is pushed
//     read : OP_RD addr      -> one reg_re strobe, then the register byte
//     other first byte       -> NAK_BYTE is pushed, that byte is the frame
//   A frame whose next byte does not arrive within TIMEOUT clocks is dropped
//   and frame_err pulses for one cycle.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   rx_empty, r_data      RX FIFO status and head byte
//   rd_uart               RX FIFO pop strobe (combinational)
//   tx_full               TX FIFO full flag
//   w_data, wr_uart       TX FIFO push byte (registered) and strobe (comb.)
//   reg_addr, reg_wdata   register bus address / write data (registered)
//   reg_we, reg_re        one-cycle bus strobes (registered)
//   reg_rdata             read data, valid one cycle after reg_re
//   busy                  high whenever the engine is not idle
//   frame_err             one-cycle pulse when a partial frame is discarded
module uart_reg_bridge #(
   parameter logic [7:0]  OP_WR    = 8'h57,
   parameter logic [7:0]  OP_RD    = 8'h52,
   parameter logic [7:0]  ACK_BYTE = 8'h4B,
   parameter logic [7:0]  NAK_BYTE = 8'h3F,
   parameter int unsigned TIMEOUT  = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   input  logic       tx_full,
   output logic [7:0] w_data,
   output logic       wr_uart,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic       frame_err
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
      DO_WR,
      DO_RD,
      WAIT_RD,
      SEND
   } state_t;

   state_t        state;
   logic          is_wr;
   logic [CW-1:0] cnt;
   logic          rx_state;

   always_comb begin
      rx_state = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
      rd_uart  = reset && !rx_empty && rx_state;
      wr_uart  = reset && !tx_full && (state == SEND);
      busy     = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         is_wr     <= 1'b0;
         cnt       <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         w_data    <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_empty) begin
                  cnt <= '0;
                  if (r_data == OP_WR) begin
                     is_wr <= 1'b1;
                     state <= GET_ADDR;
                  end else if (r_data == OP_RD) begin
                     is_wr <= 1'b0;
                     state <= GET_ADDR;
                  end else begin
                     w_data <= NAK_BYTE;
                     state  <= SEND;
                  end
               end
            end
            GET_ADDR: begin
               if (!rx_empty) begin
                  reg_addr <= r_data;
                  cnt      <= '0;
                  if (is_wr) begin
                     state <= GET_DATA;
                  end else begin
                     // strobe is registered, so it is raised on entry to DO_RD
                     reg_re <= 1'b1;
                     state  <= DO_RD;
                  end
               end else if (cnt == CNT_LAST) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GET_DATA: begin
               if (!rx_empty) begin
                  reg_wdata <= r_data;
                  cnt       <= '0;
                  // write lands in the cycle right after the data pop
                  reg_we    <= 1'b1;
                  state     <= DO_WR;
               end else if (cnt == CNT_LAST) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DO_WR: begin
               w_data <= ACK_BYTE;
               state  <= SEND;
            end
            DO_RD: begin
               state <= WAIT_RD;
            end
            WAIT_RD: begin
               w_data <= reg_rdata;
               state  <= SEND;
            end
            SEND: begin
               if (!tx_full) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge
//   Scoreboard bench for uart_reg_bridge.  Bytes written into the bench's RX
//   FIFO are also fed to a frame-level reference model which queues the
//   expected TX responses and register bus operations; an independent monitor
//   compares every DUT push/strobe against those queues.
module tb_uart_reg_bridge;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_empty = 1'b1;
   logic [7:0] r_data = 8'h00;
   logic       rd_uart;
   logic       tx_full = 1'b0;
   logic [7:0] w_data;
   logic       wr_uart;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata = 8'h00;
   logic       busy;
   logic       frame_err;

   always #5 clk = ~clk;

   uart_reg_bridge #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_empty  (rx_empty),
      .r_data    (r_data),
      .rd_uart   (rd_uart),
      .tx_full   (tx_full),
      .w_data    (w_data),
      .wr_uart   (wr_uart),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .busy      (busy),
      .frame_err (frame_err)
   );

   // ---------------- bench state ----------------
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_tx[$];
   logic [15:0] exp_wr[$];
   logic [7:0]  exp_rd[$];
   logic [7:0]  pend[$];
   int          exp_ferr = 0;
   logic [7:0]  model_mem [256];
   logic [7:0]  periph_mem [256];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_pop_neg = 0;
   int          pop_cnt = 0;
   bit          prev_push = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, act, $time);
   endtask

   // ---------------- reference model (frame level) ----------------
   function automatic void model_byte(input logic [7:0] b);
      pend.push_back(b);
      if (pend[0] == 8'h57) begin
         if (pend.size() == 3) begin
            exp_wr.push_back({pend[1], pend[2]});
            model_mem[pend[1]] = pend[2];
            exp_tx.push_back(8'h4B);
            pend.delete();
         end
      end else if (pend[0] == 8'h52) begin
         if (pend.size() == 2) begin
            exp_rd.push_back(pend[1]);
            exp_tx.push_back(model_mem[pend[1]]);
            pend.delete();
         end
      end else begin
         exp_tx.push_back(8'h3F);
         pend.delete();
      end
   endfunction

   function automatic void model_abort(input bit timed_out);
      pend.delete();
      if (timed_out) exp_ferr++;
   endfunction

   // ---------------- RX FIFO ----------------
   function automatic void rx_refresh();
      rx_empty = (rx_q.size() == 0);
      r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
   endfunction

   task automatic push_byte(input logic [7:0] b);
      rx_q.push_back(b);
      rx_refresh();
      model_byte(b);
   endtask

   // pop lands just after the edge so the DUT sees the pre-edge head byte
   always @(posedge clk) begin
      if (rd_uart) begin
         #1;
         if (rx_q.size() != 0) void'(rx_q.pop_front());
         pop_cnt++;
         rx_refresh();
      end
   end

   // ---------------- register peripheral ----------------
   always @(posedge clk) begin
      if (reg_we) periph_mem[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= periph_mem[reg_addr];
      else        reg_rdata <= 8'($urandom);
   end

   // ---------------- monitor ----------------
   logic [15:0] e_wr;
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         if (prev_push && !rx_empty) chk("pop_after_push", int'(rd_uart), 1);
         prev_push = wr_uart;
         if (rd_uart) last_pop_neg = cyc;
         if (wr_uart) begin
            chk("push_while_full", int'(tx_full), 0);
            if (exp_tx.size() == 0) fail_now("unexpected_push", int'(w_data));
            else chk("tx_byte", int'(w_data), int'(exp_tx.pop_front()));
         end
         if (reg_we) begin
            if (exp_wr.size() == 0) fail_now("unexpected_reg_we", int'(reg_addr));
            else begin
               e_wr = exp_wr.pop_front();
               chk("we_addr", int'(reg_addr), int'(e_wr[15:8]));
               chk("we_data", int'(reg_wdata), int'(e_wr[7:0]));
            end
         end
         if (reg_re) begin
            if (exp_rd.size() == 0) fail_now("unexpected_reg_re", int'(reg_addr));
            else chk("re_addr", int'(reg_addr), int'(exp_rd.pop_front()));
         end
         if (frame_err) begin
            if (exp_ferr == 0) fail_now("unexpected_frame_err", 1);
            else begin
               exp_ferr--;
               // TIMEOUT clocks from the pop edge to the asserting edge,
               // which is TIMEOUT+1 negedge samples apart
               chk("frame_err_latency", cyc - last_pop_neg, TO + 1);
            end
         end
      end else begin
         prev_push = 1'b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_rx_empty(input int max, input string name);
      int n = 0;
      while (rx_q.size() != 0 && n < max) begin
         tick();
         n++;
      end
      if (rx_q.size() != 0) fail_now(name, rx_q.size());
   endtask

   task automatic drain(input int max);
      int  n = 0;
      bit  done = 1'b0;
      tx_full = 1'b0;
      while (!done && n < max) begin
         done = (exp_tx.size() == 0) && (exp_wr.size() == 0) && (exp_rd.size() == 0)
                && (exp_ferr == 0) && (rx_q.size() == 0) && !busy;
         if (!done) begin
            tick();
            n++;
         end
      end
      if (!done) fail_now("drain_timeout", exp_tx.size());
   endtask

   task automatic check_reset_values();
      chk("rst_busy",      int'(busy),      0);
      chk("rst_reg_we",    int'(reg_we),    0);
      chk("rst_reg_re",    int'(reg_re),    0);
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_reg_addr",  int'(reg_addr),  0);
      chk("rst_reg_wdata", int'(reg_wdata), 0);
      chk("rst_w_data",    int'(w_data),    0);
      chk("rst_wr_uart",   int'(wr_uart),   0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int p0;
      int qs;
      for (int i = 0; i < 256; i++) begin
         model_mem[i]  = 8'(i * 7 + 3);
         periph_mem[i] = 8'(i * 7 + 3);
      end

      reset = 1'b0;
      repeat (3) tick();
      check_reset_values();
      reset = 1'b1;
      tick();

      // write then read back
      p0 = pop_cnt;
      push_byte(8'h57); push_byte(8'h10); push_byte(8'hA5);
      drain(100);
      chk("write_pop_count", pop_cnt - p0, 3);
      push_byte(8'h52); push_byte(8'h10);
      drain(100);

      // unknown opcode followed by a read
      push_byte(8'h33); push_byte(8'h52); push_byte(8'h07);
      drain(100);

      // TX back-pressure with a following frame already waiting
      tx_full = 1'b1;
      push_byte(8'h57); push_byte(8'h20); push_byte(8'h3C);
      wait_rx_empty(50, "bp_frame_not_consumed");
      push_byte(8'h52); push_byte(8'h20);
      qs = rx_q.size();
      repeat (50) tick();
      chk("bp_no_pops", rx_q.size(), qs);
      chk("bp_busy", int'(busy), 1);
      tx_full = 1'b0;
      #1;
      chk("bp_push_on_release", int'(wr_uart), 1);
      chk("bp_push_byte", int'(w_data), 8'h4B);
      drain(100);

      // timeout after the address byte
      push_byte(8'h57); push_byte(8'h10);
      wait_rx_empty(50, "to_bytes_not_consumed");
      model_abort(1'b1);
      repeat (TO + 6) tick();
      chk("to_frame_err_seen", exp_ferr, 0);
      chk("to_back_idle", int'(busy), 0);
      push_byte(8'h52); push_byte(8'h10);
      drain(100);

      // reset mid-frame, with the next frame already in the FIFO
      push_byte(8'h57);
      wait_rx_empty(50, "rst_opcode_not_consumed");
      model_abort(1'b0);
      reset = 1'b0;
      push_byte(8'h52); push_byte(8'h01);
      #1;
      chk("rst_rd_gated", int'(rd_uart), 0);
      tick();
      check_reset_values();
      chk("rst_rd_gated2", int'(rd_uart), 0);
      reset = 1'b1;
      drain(100);

      // three write frames preloaded back to back
      push_byte(8'h57); push_byte(8'h01); push_byte(8'h11);
      push_byte(8'h57); push_byte(8'h02); push_byte(8'h22);
      push_byte(8'h57); push_byte(8'h03); push_byte(8'h33);
      drain(200);

      // randomized frames with random gaps and TX back-pressure
      for (int f = 0; f < 60; f++) begin
         int sel = $urandom_range(0, 19);
         logic [7:0] op;
         logic [7:0] junk;
         int nbytes;
         if (sel < 9)       op = 8'h57;
         else if (sel < 18) op = 8'h52;
         else begin
            junk = 8'($urandom);
            if (junk == 8'h57 || junk == 8'h52) junk = 8'h00;
            op = junk;
         end
         nbytes = (op == 8'h57) ? 3 : (op == 8'h52) ? 2 : 1;
         for (int b = 0; b < nbytes; b++) begin
            logic [7:0] v;
            if (b == 0) v = op;
            else if (b == 1) v = 8'($urandom_range(0, 15));
            else v = 8'($urandom);
            push_byte(v);
            repeat ($urandom_range(0, 3)) begin
               tx_full = ($urandom_range(0, 3) == 0);
               tick();
            end
         end
      end
      drain(2000);

      chk("end_exp_tx_empty", exp_tx.size(), 0);
      chk("end_exp_wr_empty", exp_wr.size(), 0);
      chk("end_exp_rd_empty", exp_rd.size(), 0);
      chk("end_rx_empty", rx_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
